// File: rtl/aud_btm_rx.sv
// AUD branch-trace receiver: nibble bus decoder, record assembly and
// first-word-fall-through record FIFO with sticky overflow accounting.
module aud_btm_rx #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              aud_ck,
    input  logic              rst_n,
    input  logic [3:0]        aud_data,
    input  logic              aud_nsync,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_mode,
    output logic              out_partial,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic              buserror,
    output logic [7:0]        drop_cnt
);
    localparam int NW = ADDR_W / 4;
    localparam int CW = $clog2(NW + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HDR, RECV} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        mode;
        logic              partial;
    } rec_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] last_good_q, last_good_d;
    logic [ADDR_W-1:0] asm_q, asm_d;
    logic              buserror_q, buserror_d;
    logic              pend_q, pend_d;
    rec_t              pend_rec_q, pend_rec_d;
    rec_t              mem_q [FIFO_DEPTH];
    rec_t              mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    rec_t              rec;
    int                e_int;
    logic              pop, full, accept, drop;

    // Record assembly: nibble decode and staging of finished records
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        last_good_d = last_good_q;
        asm_d       = asm_q;
        buserror_d  = 1'b0;
        pend_d      = 1'b0;
        pend_rec_d  = pend_rec_q;

        e_int = 1 << mode_q;
        if (e_int > NW) e_int = NW;

        rec = '0;
        for (int i = 0; i < NW; i++) begin
            rec.addr[4*i +: 4] = (i < int'(cnt_q)) ? asm_q[4*i +: 4]
                                                   : last_good_q[4*i +: 4];
        end
        rec.mode    = mode_q;
        rec.partial = (int'(cnt_q) != e_int);

        if (aud_nsync) begin
            cnt_d = '0;
            if (state_q == RECV && cnt_q != '0) begin
                pend_d     = 1'b1;
                pend_rec_d = rec;
                if (!rec.partial) last_good_d = rec.addr;
            end
            unique case (1'b1)
                (aud_data == 4'b0011): state_d = IDLE;
                (aud_data[3:2] == 2'b10): begin
                    mode_d  = aud_data[1:0];
                    state_d = HDR;
                end
                default: begin
                    buserror_d = 1'b1;
                    state_d    = IDLE;
                end
            endcase
        end else if (state_q == IDLE) begin
            buserror_d = 1'b1;
        end else if (int'(cnt_q) < NW) begin
            asm_d[4*int'(cnt_q) +: 4] = aud_data;
            cnt_d   = cnt_q + CW'(1);
            state_d = RECV;
        end else begin
            buserror_d = 1'b1;
        end
    end

    // FIFO: a pop frees the slot so a push into a full FIFO still lands
    always_comb begin
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        pop    = (count_q != '0) && out_ready;
        full   = (count_q == (PW+1)'(FIFO_DEPTH));
        accept = pend_q && (!full || pop);
        drop   = pend_q && full && !pop;

        if (accept) begin
            mem_d[wr_q] = pend_rec_q;
            wr_d        = wr_q + PW'(1);
        end
        if (pop) rd_d = rd_q + PW'(1);

        unique case ({accept, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow)             drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge aud_ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= '0;
            last_good_q <= '0;
            asm_q       <= '0;
            buserror_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_rec_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            last_good_q <= last_good_d;
            asm_q       <= asm_d;
            buserror_q  <= buserror_d;
            pend_q      <= pend_d;
            pend_rec_q  <= pend_rec_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_addr    = out_valid ? mem_q[rd_q].addr : '0;
    assign out_mode    = out_valid ? mem_q[rd_q].mode : '0;
    assign out_partial = out_valid ? mem_q[rd_q].partial : 1'b0;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;
    assign buserror    = buserror_q;

endmodule

// File: doc/aud_btm_rx.md
AUD_BTM_RX -- requirements
Module: aud_btm_rx

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning branch address width in bits; legal values are multiples of 4 from 8 to 32.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning record FIFO entries; legal values are powers of 2 from 2 to 64.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- aud_ck  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- aud_data  in  4  AUD nibble bus.
- aud_nsync  in  1  1 = sync/command nibble, 0 = address nibble.
- out_addr  out  ADDR_W  head-of-FIFO branch address.
- out_mode  out  2  head-of-FIFO header mode field.
- out_partial  out  1  head-of-FIFO record was incomplete.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head record.
- overflow  out  1  sticky: a record was dropped.
- clr_overflow  in  1  clears overflow and drop_cnt.
- buserror  out  1  illegal bus state sampled last cycle.
- drop_cnt  out  8  count of dropped records, saturating.

Function
REQ-004 The block SHALL sample aud_data and aud_nsync on the rising edge of aud_ck and run state machine IDLE, HDR, RECV.
REQ-005 In any state, aud_nsync=1 with aud_data=4'b0011 SHALL be a normal sync symbol; aud_nsync=1 with aud_data[3:2]=2'b10 SHALL latch mode=aud_data[1:0] and enter HDR; any other aud_nsync=1 nibble SHALL set buserror for one cycle and enter IDLE.
REQ-006 The expected nibble count SHALL be E = min(1<<mode, ADDR_W/4).
REQ-007 In HDR or RECV, aud_nsync=0 SHALL write aud_data into bits [4*cnt+3:4*cnt] of the assembly register, increment cnt, and enter RECV.
REQ-008 When cnt reaches ADDR_W/4, further address nibbles SHALL be ignored, cnt SHALL hold, and buserror SHALL pulse once per ignored nibble.
REQ-009 In IDLE, aud_nsync=0 SHALL set buserror for one cycle and SHALL discard the nibble.
REQ-010 A record SHALL be pushed on the edge that samples aud_nsync=1 while in RECV, with cnt>0, and SHALL contain:
- addr: last_good with its low 4*cnt bits replaced by received nibbles.
- mode: the latched mode.
- partial = (cnt != E).
REQ-011 last_good SHALL be updated to the record address only when partial=0.
REQ-012 cnt SHALL clear to 0 on every aud_nsync=1 sample, and the same nibble SHALL be decoded per REQ-005 in that cycle, so back-to-back header-terminated records lose no cycles.
REQ-013 The FIFO SHALL be first-word-fall-through: out_valid=1 whenever it is non-empty, and out_addr, out_mode and out_partial SHALL show the oldest entry.
REQ-014 A pop SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-015 A pushed record SHALL appear on out_valid on the edge after the push edge when the FIFO was empty (one-cycle latency).
REQ-016 A push when the FIFO is full and no pop occurs on the same edge SHALL drop the record, set overflow, and increment drop_cnt, saturating at 255.
REQ-017 A simultaneous push and pop when the FIFO is full SHALL accept the push.
REQ-018 A simultaneous push and pop when the FIFO is empty SHALL not pop, and SHALL leave the pushed entry present.
REQ-019 clr_overflow=1 SHALL clear overflow and drop_cnt on that edge; a drop on the same edge SHALL take priority, leaving overflow=1 and drop_cnt=1.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL be tracked with log2(FIFO_DEPTH)+1 bits.

Reset
REQ-021 On rst_n=0, asynchronously, the block SHALL go to IDLE and clear to 0: cnt, mode, last_good, the assembly register, the FIFO pointers, out_valid, overflow, drop_cnt and buserror.
REQ-022 A record in assembly when reset asserts SHALL be discarded and not pushed.
REQ-023 out_addr, out_mode and out_partial SHALL be 0 after reset.
REQ-024 Normal operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-025 Full record: header 4'b1011 (mode 3), then 8 nibbles 1,2,...,8 with nsync=0, then sync 4'b0011 -> one record {addr=0x87654321, mode=3, partial=0}, out_valid one cycle later.
REQ-026 Partial record: with last_good=0x87654321, header 4'b1011 then 2 nibbles A,B, then a new header -> record {addr=0x8765 43BA, partial=1}; last_good unchanged; the new header is latched.
REQ-027 Overflow: FIFO_DEPTH=2, out_ready=0, push 3 records -> the first 2 are kept, overflow=1, drop_cnt=1; pulsing clr_overflow -> both back to 0.
REQ-028 Full simultaneous: FIFO full, push and pop on the same edge -> occupancy stays at FIFO_DEPTH, no drop, the newest entry is at the tail.
REQ-029 Bus errors: nsync=1 with 4'b0110 -> buserror=1 for one cycle, IDLE; a nibble with nsync=0 in IDLE -> buserror=1, no record.
REQ-030 Reset mid-record: rst_n=0 after 3 nibbles -> no record, all outputs 0; the next full record assembles on last_good=0.
